mac1_feeder: RTL
================

// Module: mac1_feeder
// PURPOSE
//  Upstream driver and downstream collector for the 16-lane 8x8 MAC pipeline (mac1).
//  - Assembles a byte stream into 128-bit weight and pixel vectors and drives them into the MAC.
//  - Tracks the MAC's fixed pipeline latency with a token shift register.
//  - Captures each 20-bit sum into a result FIFO with valid/ready output.
//  - Credit logic ensures no MAC result is ever lost.
// PARAMETERS
//  MAC_LAT    3  cycles from a new vector on pixels/weights to the matching mac_sum (mac1 = 3)
//  RES_DEPTH  4  result FIFO entries; power of two, >=2
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  in_data    in   8    input byte (pixel or weight)
//  in_wt      in   1    1 = byte is a weight, 0 = pixel; must be constant across a 16-byte group
//  in_valid   in   1    in_data valid
//  in_ready   out  1    byte accepted when in_valid & in_ready
//  pixels     out  128  pixel vector to MAC; byte k (k = 0..15, arrival order) at [127-8k -: 8]
//  weights    out  128  weight vector to MAC; same lane ordering
//  mac_sum    in   20   MAC output (mac1 sumOUT)
//  res_data   out  20   result FIFO head
//  res_valid  out  1    FIFO non-empty
//  res_ready  in   1    pop when res_valid & res_ready
//  busy       out  1    1 whenever tokens are in flight or the FIFO is non-empty
// BEHAVIOUR
//  - Reset values: pixels = 0, weights = 0, res_valid = 0, busy = 0, in_ready = 0 in the reset cycle;
//    FSM -> IDLE, byte count = 0, tokens = 0, FIFO empty, res_data = 0.
//  - FSM states:
//    IDLE: in_ready = 1. First accepted byte goes to lane 0 of the weight shadow (in_wt = 1, -> LOAD_W)
//      or the pixel shadow (in_wt = 0, -> COLLECT).
//    LOAD_W: in_ready = 1 only when no tokens are in flight. Weights never change under an in-flight vector.
//      On the 16th byte, the weights output takes the full shadow on the next edge; state -> IDLE.
//    COLLECT: in_ready = 1. On the 16th byte -> ISSUE.
//    ISSUE: in_ready = 0. When credit is available, pixels <= shadow, a token enters stage 0, state -> IDLE.
//      Otherwise the FSM stays in ISSUE.
//  - Credit rule: credit = (FIFO count + tokens in flight) < RES_DEPTH.
//  - Token pipeline: MAC_LAT stages. When a token exits, mac_sum is pushed to the FIFO in that same cycle.
//    FIFO overflow is impossible by construction.
//  - Simultaneous push and pop: both take effect; count is unchanged. Pop on empty and push-when-full
//    cannot occur; the bench asserts this.
//  - pixels and weights hold their values between updates; the MAC re-sampling stale data is harmless
//    because no token accompanies it.
//  - Sums are unsigned 20-bit, passed through unchanged; the feeder does no arithmetic on data.
//  - Mixing in_wt inside a group: the byte is taken per the group's first in_wt; the mixed flag is ignored.
//  - Reset mid-group or with tokens in flight: everything is discarded.
//    No result appears for pre-reset vectors. Weights return to 0.
//  - Throughput: 1 vector per 17 cycles (16 bytes + ISSUE) when no backpressure is applied.
// CONFIGURATION
//  MAC_FEED_TAG_EN defined:
//  - Adds output res_tag [3:0], stored in the FIFO alongside res_data.
//  - The tag is a per-result sequence number: 0 after reset, +1 per issued vector, wraps 15 -> 0.
//  - The tag is attached at issue and travels with the token.
//  MAC_FEED_TAG_EN undefined: no res_tag port and no tag storage; all else identical.
// TESTING
//  1. Load 16 weights of 0x01, then pixels 1..16, res_ready = 1
//     -> one res_data = 136, exactly MAC_LAT+1 cycles after ISSUE.
//  2. Weights and pixels all 0xFF -> res_data = 1040400 (0xFE010), no truncation.
//  3. res_ready = 0, issue 6 pixel groups (weights = 1, pixels all k for group k = 1..6)
//     -> 4 results buffered (16,32,48,64), FSM stalls in ISSUE, busy = 1.
//     Release res_ready -> results 16..96 emerge in order, none lost or duplicated.
//  4. Pixel group in flight, then a weight group sent
//     -> in_ready low in LOAD_W until tokens drain; the pending sum uses the old weights.
//  5. Assert rst after 9 pixel bytes and again 1 cycle after ISSUE
//     -> no res_valid afterwards, all outputs 0; a fresh group then yields the correct sum.
//  6. With MAC_FEED_TAG_EN: 18 back-to-back groups -> res_tag sequence 0..15, 0, 1.
//     Without it: same res_data values.

Source files
------------

// File: rtl/mac1_feeder.sv
// mac1_feeder: packs a byte stream into 128-bit weight/pixel vectors for mac1, tracks its latency with tokens, buffers sums.
// Latency: a result reaches res_valid MAC_LAT+1 cycles after the issue edge; 16 bytes + 1 issue cycle per vector.
// Backpressure: in_ready drops in ISSUE without credit and in LOAD_W while tokens fly; MAC_FEED_TAG_EN adds res_tag.

module mac1_feeder_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    pop   = pop_rdy && (cnt_q != '0);
    if (push_vld) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push_vld && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push_vld) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_vld = (cnt_q != '0);
  assign pop_dat = mem_q[rd_q];
  assign cnt     = cnt_q;
endmodule

module mac1_feeder #(
  parameter int MAC_LAT   = 3,
  parameter int RES_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_wt,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] pixels,
  output logic [127:0] weights,
  input  logic [19:0]  mac_sum,
  output logic [19:0]  res_data,
  output logic         res_valid,
  input  logic         res_ready,
`ifdef MAC_FEED_TAG_EN
  output logic [3:0]   res_tag,
`endif
  output logic         busy
);
`ifdef MAC_FEED_TAG_EN
  localparam int RW = 24;
`else
  localparam int RW = 20;
`endif

  typedef enum logic [1:0] {IDLE, LOAD_W, COLLECT, ISSUE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [127:0]            shadow_q, shadow_d;
  logic [127:0]            pixels_q, pixels_d;
  logic [127:0]            weights_q, weights_d;
  logic                    in_ready_q, in_ready_d;
  logic [MAC_LAT:0]        tok_q, tok_d;
  logic                    accept, credit;
  int                      occ;
  logic [$clog2(RES_DEPTH):0] fifo_cnt;
  logic                    fifo_vld;
  logic [RW-1:0]           fifo_push_dat, fifo_pop_dat;

  // tok_q[0] marks a fresh vector on pixels; tok_q[MAC_LAT] lines up with its mac_sum.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    pixels_d  = pixels_q;
    weights_d = weights_q;
    tok_d     = {tok_q[MAC_LAT-1:0], 1'b0};
    accept    = in_valid && in_ready_q;
    occ       = int'(fifo_cnt);
    for (int i = 0; i <= MAC_LAT; i++) occ += int'(tok_q[i]);
    credit    = (occ < RES_DEPTH);

    if (accept) begin
      for (int k = 0; k < 16; k++)
        if (cnt_q == 4'(k)) shadow_d[127-8*k -: 8] = in_data;
    end

    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = 4'd1;
        state_d = in_wt ? LOAD_W : COLLECT;
      end
      LOAD_W: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 4'd15) begin
          weights_d = shadow_d;
          state_d   = IDLE;
        end
      end
      COLLECT: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 4'd15) state_d = ISSUE;
      end
      ISSUE: if (credit) begin
        pixels_d = shadow_q;
        tok_d[0] = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == COLLECT) ||
                 ((state_d == LOAD_W) && (tok_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pixels_q   <= '0;
      weights_q  <= '0;
      in_ready_q <= 1'b0;
      tok_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pixels_q   <= pixels_d;
      weights_q  <= weights_d;
      in_ready_q <= in_ready_d;
      tok_q      <= tok_d;
    end
  end

`ifdef MAC_FEED_TAG_EN
  logic [3:0] tag_q, tag_d;
  logic [3:0] tag_pipe_q [MAC_LAT+1];
  logic [3:0] tag_pipe_d [MAC_LAT+1];

  always_comb begin
    tag_d         = tag_q;
    tag_pipe_d[0] = tag_q;
    for (int i = 1; i <= MAC_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    if ((state_q == ISSUE) && credit) tag_d = tag_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      for (int i = 0; i <= MAC_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      tag_q      <= tag_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign fifo_push_dat = {tag_pipe_q[MAC_LAT], mac_sum};
  assign res_tag       = fifo_pop_dat[23:20];
`else
  assign fifo_push_dat = mac_sum;
`endif

  mac1_feeder_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (tok_q[MAC_LAT]),
    .push_dat (fifo_push_dat),
    .pop_rdy  (res_ready),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_pop_dat),
    .cnt      (fifo_cnt)
  );

  assign in_ready  = in_ready_q;
  assign pixels    = pixels_q;
  assign weights   = weights_q;
  assign res_data  = fifo_pop_dat[19:0];
  assign res_valid = fifo_vld;
  assign busy      = (|tok_q) | fifo_vld;
endmodule
